// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode values, ALU operation encoding and the
// packed datapath control bundle produced by the decode lookup.
package decode_pkg;

  localparam logic [4:0] OP_MOV_IMM = 5'b10111;
  localparam logic [4:0] OP_ADD     = 5'b11000;
  localparam logic [4:0] OP_MOV_REG = 5'b11011;
  localparam logic [4:0] OP_MUL     = 5'b11111;
  localparam logic [4:0] OP_SUB     = 5'b11110;
  localparam logic [4:0] OP_XOR     = 5'b01100;
  localparam logic [4:0] OP_LOAD    = 5'b00001;
  localparam logic [4:0] OP_STORE   = 5'b00010;
  localparam logic [4:0] OP_BRANCH  = 5'b00100;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_XOR = 2'b11
  } alu_ctrl_e;

  typedef struct packed {
    alu_ctrl_e alu_ctrl;
    logic      reg_write;
    logic      mem_write;
    logic      branch;
    logic      mem_to_reg;
    logic      alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{alu_ctrl: ALU_ADD, reg_write: 1'b0, mem_write: 1'b0,
                                  branch: 1'b0, mem_to_reg: 1'b0, alu_src: 1'b0};

endpackage

// File: rtl/decode_lut.sv
// Combinational opcode/operand-type decode into a control bundle.
// Illegal instructions produce no controls and are treated as scalar so they
// occupy exactly one beat.
module decode_lut
  import decode_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic       rd_type,
  input  logic       rs1_type,
  input  logic       rs2_type,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       is_vector
);

  logic  known;
  logic  any_vec;
  ctrl_t raw;

  // Opcode table plus operand-type legality rules.
  always_comb begin
    raw   = CTRL_NONE;
    known = 1'b1;
    unique case (opcode)
      OP_MOV_IMM: begin raw.reg_write = 1'b1; raw.alu_src = 1'b1; end
      OP_ADD:     raw.reg_write = 1'b1;
      OP_MOV_REG: raw.reg_write = 1'b1;
      OP_MUL:     begin raw.alu_ctrl = ALU_MUL; raw.reg_write = 1'b1; end
      OP_SUB:     begin raw.alu_ctrl = ALU_SUB; raw.reg_write = 1'b1; end
      OP_XOR:     begin raw.alu_ctrl = ALU_XOR; raw.reg_write = 1'b1; end
      OP_LOAD:    begin raw.reg_write = 1'b1; raw.mem_to_reg = 1'b1; raw.alu_src = 1'b1; end
      OP_STORE:   begin raw.mem_write = 1'b1; raw.alu_src = 1'b1; end
      OP_BRANCH:  begin raw.alu_ctrl = ALU_SUB; raw.branch = 1'b1; end
      default:    known = 1'b0;
    endcase

    any_vec = rd_type | rs1_type | rs2_type;
    // A scalar destination cannot be fed from vector sources.
    illegal = !known
           || ((opcode == OP_BRANCH) && any_vec)
           || (!rd_type && (rs1_type || rs2_type));

    ctrl      = illegal ? CTRL_NONE : raw;
    is_vector = any_vec && !illegal;
  end

endmodule

// File: rtl/vec_issue_decoder.sv
// Vector issue decoder: accepts one instruction at a time and emits one
// registered control beat per group of ALU_LANES lanes. A new instruction is
// taken in the same cycle the final beat is consumed, so scalars stream at
// full rate.
//
// state  | meaning
// IDLE   | no instruction held, out_valid low, ready for input
// ISSUE  | presenting beats of the held instruction
module vec_issue_decoder
  import decode_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int ALU_LANES = 1,
  localparam int LBW      = (LANES > 1) ? $clog2(LANES) : 1
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4:0]     opcode,
  input  logic           rd_type,
  input  logic           rs1_type,
  input  logic           rs2_type,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     alu_ctrl,
  output logic           reg_write,
  output logic           mem_write,
  output logic           branch,
  output logic           mem_to_reg,
  output logic           alu_src,
  output logic [LBW-1:0] lane_base,
  output logic           last_beat,
  output logic           illegal
);

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_e;

  localparam logic [LBW-1:0] LANE_STEP = LBW'(ALU_LANES);
  localparam logic [LBW-1:0] LAST_BASE = LBW'(LANES - ALU_LANES);
  localparam logic           ONE_BEAT  = (LANES == ALU_LANES);

  state_e          state;
  ctrl_t           ctrl_q;
  ctrl_t           lut_ctrl;
  logic            lut_illegal;
  logic            lut_vector;
  logic            take_in;
  logic            take_out;
  logic [LBW-1:0]  next_base;

  decode_lut u_decode_lut (
    .opcode    (opcode),
    .rd_type   (rd_type),
    .rs1_type  (rs1_type),
    .rs2_type  (rs2_type),
    .ctrl      (lut_ctrl),
    .illegal   (lut_illegal),
    .is_vector (lut_vector)
  );

  assign in_ready  = !rst && ((state == S_IDLE) || (out_valid && out_ready && last_beat));
  assign take_in   = in_valid && in_ready;
  assign take_out  = out_valid && out_ready;
  assign next_base = lane_base + LANE_STEP;

  assign alu_ctrl   = ctrl_q.alu_ctrl;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_write  = ctrl_q.mem_write;
  assign branch     = ctrl_q.branch;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src    = ctrl_q.alu_src;

  // Issue FSM with registered beat outputs; new instructions win over beat advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      ctrl_q    <= CTRL_NONE;
      lane_base <= '0;
      last_beat <= 1'b0;
      illegal   <= 1'b0;
    end else if (take_in) begin
      state     <= S_ISSUE;
      out_valid <= 1'b1;
      ctrl_q    <= lut_ctrl;
      lane_base <= '0;
      last_beat <= !lut_vector || ONE_BEAT;
      illegal   <= lut_illegal;
    end else if (take_out) begin
      if (last_beat) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
      end else begin
        lane_base <= next_base;
        last_beat <= (next_base == LAST_BASE);
      end
    end
  end

endmodule

// File: tb/tb_vec_issue_decoder.sv
// Scoreboard bench for vec_issue_decoder (LANES=4, ALU_LANES=1).
module tb_vec_issue_decoder;

  localparam int LANES     = 4;
  localparam int ALU_LANES = 1;

  typedef struct packed {
    logic [1:0] alu;
    logic       rw;
    logic       mw;
    logic       br;
    logic       mtr;
    logic       src;
    logic [1:0] lane;
    logic       last;
    logic       ill;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] opcode = 5'd0;
  logic       rd_type = 1'b0, rs1_type = 1'b0, rs2_type = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] alu_ctrl;
  logic       reg_write, mem_write, branch, mem_to_reg, alu_src;
  logic [1:0] lane_base;
  logic       last_beat;
  logic       illegal;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t q[$];

  vec_issue_decoder #(.LANES(LANES), .ALU_LANES(ALU_LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .rd_type    (rd_type),
    .rs1_type   (rs1_type),
    .rs2_type   (rs2_type),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_ctrl   (alu_ctrl),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .branch     (branch),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .lane_base  (lane_base),
    .last_beat  (last_beat),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  function automatic beat_t actual();
    beat_t b;
    b.alu = alu_ctrl; b.rw = reg_write; b.mw = mem_write; b.br = branch;
    b.mtr = mem_to_reg; b.src = alu_src; b.lane = lane_base; b.last = last_beat;
    b.ill = illegal;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: expand an accepted instruction into its expected beats.
  task automatic push_instr(input logic [4:0] op, input logic rdt, input logic r1t, input logic r2t);
    logic [1:0] alu;
    logic rw, mw, br, mtr, src, known, vec, ill;
    int beats;
    beat_t b;
    alu = 2'b00; {rw, mw, br, mtr, src} = 5'b0; known = 1'b1;
    case (op)
      5'b10111: begin rw = 1; src = 1; end
      5'b11000: rw = 1;
      5'b11011: rw = 1;
      5'b11111: begin alu = 2'b10; rw = 1; end
      5'b11110: begin alu = 2'b01; rw = 1; end
      5'b01100: begin alu = 2'b11; rw = 1; end
      5'b00001: begin rw = 1; mtr = 1; src = 1; end
      5'b00010: begin mw = 1; src = 1; end
      5'b00100: begin alu = 2'b01; br = 1; end
      default:  known = 1'b0;
    endcase
    vec = rdt | r1t | r2t;
    ill = !known || (op == 5'b00100 && vec) || (!rdt && (r1t || r2t));
    if (ill) begin
      alu = 2'b00; {rw, mw, br, mtr, src} = 5'b0; vec = 1'b0;
    end
    beats = vec ? LANES / ALU_LANES : 1;
    for (int k = 0; k < beats; k++) begin
      b.alu = alu; b.rw = rw; b.mw = mw; b.br = br; b.mtr = mtr; b.src = src;
      b.lane = 2'(k * ALU_LANES);
      b.last = (k == beats - 1);
      b.ill  = ill;
      q.push_back(b);
    end
  endtask

  // Monitor: compares presented beats against the scoreboard head every cycle.
  always @(negedge clk) begin
    logic exp_ir;
    #2;
    if (rst) begin
      check("in_ready_in_reset", 32'(in_ready), 32'(1'b0));
    end else begin
      if (q.size() == 0) exp_ir = 1'b1;
      else               exp_ir = out_ready && q[0].last;
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        check("beat", 32'(actual()), 32'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // One driver cycle: drive at negedge, decide acceptance, record it at posedge.
  task automatic cycle(input logic v, input logic [4:0] op, input logic rdt, input logic r1t,
                       input logic r2t, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid = v; opcode = op; rd_type = rdt; rs1_type = r1t; rs2_type = r2t;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    @(posedge clk);
    if (acc) push_instr(op, rdt, r1t, r2t);
  endtask

  task automatic issue(input logic [4:0] op, input logic rdt, input logic r1t, input logic r2t,
                       input bit rand_ready, output int tries);
    logic acc;
    logic ordy;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 50) begin
      ordy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(1'b1, op, rdt, r1t, r2t, ordy, acc);
      tries++;
    end
    if (!acc) begin
      n_errors++;
      $display("FAIL issue_timeout: opcode %b not accepted within 50 cycles", op);
    end
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    cycle(1'b0, $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), ordy, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      idle(1'b1);
      n++;
    end
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: %0d beats still pending", q.size());
    end
    idle(1'b1);
  endtask

  task automatic check_reset_vals();
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_outputs", 32'(actual()), 32'(0));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      q.delete();
    end
    @(negedge clk);
    rst = 1'b0;
    #3;
    check_reset_vals();
  endtask

  logic [4:0] ops [10] = '{5'b10111, 5'b11000, 5'b11011, 5'b11111, 5'b11110,
                           5'b01100, 5'b00001, 5'b00010, 5'b00100, 5'b00000};

  initial begin
    int t;
    logic acc;
    logic [4:0] op;

    do_reset(3);

    // Scalar add, consumer always ready.
    issue(5'b11000, 0, 0, 0, 0, t);
    drain();

    // Vector mul: four beats; the next instruction waits for the final beat.
    issue(5'b11111, 1, 1, 1, 0, t);
    issue(5'b11000, 0, 0, 0, 0, t);
    check("vec_accept_wait", 32'(t), 32'd4);
    drain();

    // Vector mul with a three-cycle stall at lane 1.
    issue(5'b11111, 1, 1, 1, 0, t);
    cycle(0, 0, 0, 0, 0, 1'b1, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 1'b0, acc);
    drain();

    // Illegal instructions.
    issue(5'b00100, 0, 1, 0, 0, t);
    issue(5'b00100, 1, 1, 0, 0, t);
    issue(5'b00000, 0, 0, 0, 0, t);
    issue(5'b11000, 0, 1, 1, 0, t);
    drain();

    // Back-to-back scalars with no bubble.
    issue(5'b01100, 0, 0, 0, 0, t);
    issue(5'b11110, 0, 0, 0, 0, t);
    check("b2b_no_bubble", 32'(t), 32'd1);
    drain();

    // Reset while lane 2 of a vector is on the output.
    issue(5'b11111, 1, 0, 1, 0, t);
    cycle(0, 0, 0, 0, 0, 1'b1, acc);
    cycle(0, 0, 0, 0, 0, 1'b1, acc);
    @(negedge clk);
    #2;
    check("pre_reset_lane", 32'(lane_base), 32'd2);
    do_reset(1);
    repeat (4) idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                       : ops[$urandom_range(0, 9)];
      issue(op, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1, t);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 1));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vec_issue_decoder.md
VEC_ISSUE_DECODER -- requirements
Module: vec_issue_decoder

Interface
REQ-001 SHALL have parameters: LANES, default 4, total SIMD lanes per vector register (power of two, >=1).
REQ-002 SHALL have parameters: ALU_LANES, default 1, lanes processed per beat (power of two, divides LANES).
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  in  1  instruction present.
REQ-006 SHALL have ports: in_ready  out  1  decoder accepts instruction this cycle.
REQ-007 SHALL have ports: opcode  in  5  instruction opcode.
REQ-008 SHALL have ports: rd_type, rs1_type, rs2_type  in  1 each  1 = vector operand, 0 = scalar.
REQ-009 SHALL have ports: out_valid  out  1  control beat present.
REQ-010 SHALL have ports: out_ready  in  1  execute stage consumes beat.
REQ-011 SHALL have ports: alu_ctrl  out  2  00 add/pass, 01 sub, 10 mul, 11 xor.
REQ-012 SHALL have ports: reg_write, mem_write, branch, mem_to_reg, alu_src  out  1 each  datapath controls.
REQ-013 SHALL have ports: lane_base  out  max(1,$clog2(LANES))  first lane of current beat.
REQ-014 SHALL have ports: last_beat  out  1  current beat is final for the instruction.
REQ-015 SHALL have ports: illegal  out  1  undefined opcode or illegal operand-type mix.

Function
REQ-016 SHALL decode: 10111 mov-imm (alu 00, rw, src 1); 11000 add (00, rw); 11011 mov-reg (00, rw); 11111 mul (10, rw); 11110 sub (01, rw); 01100 xor (11, rw); 00001 load (00, rw, mem_to_reg, src 1); 00010 store (00, mem_write, src 1); 00100 branch (01, branch); unlisted controls 0.
REQ-017 SHALL treat instruction as vector if any type bit is 1; vector issues BEATS = LANES/ALU_LANES beats, scalar issues 1 beat.
REQ-018 SHALL flag illegal (all controls 0, 1 beat) for undefined opcode, branch with any vector type, or rd_type=0 with rs1_type or rs2_type = 1.
REQ-019 SHALL implement FSM IDLE/ISSUE: IDLE->ISSUE on in_valid&&in_ready; ISSUE->IDLE on accept of last beat with no new instruction accepted; stays in ISSUE on back-to-back accept.
REQ-020 SHALL drive in_ready = !rst && (state==IDLE || (out_valid && out_ready && last_beat)).
REQ-021 SHALL register outputs: accepted instruction appears on out_valid the next cycle (latency 1), lane_base=0.
REQ-022 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-023 SHALL on accepted non-last beat increment lane_base by ALU_LANES, controls unchanged.
REQ-024 SHALL assert last_beat when lane_base == LANES-ALU_LANES (vector) or always (scalar/illegal); LANES==ALU_LANES gives single-beat vectors.
REQ-025 SHALL on simultaneous last-beat accept and in_valid load the new instruction with no bubble (full throughput for scalars).
REQ-026 SHALL ignore opcode/type inputs when in_ready=0.

Reset
REQ-027 SHALL on rst=1 at a clock edge force state IDLE, out_valid 0, alu_ctrl 00, all control bits 0, lane_base 0, last_beat 0, illegal 0.
REQ-028 SHALL abort any in-flight vector instruction on reset mid-issue; no further beats emitted.

Structure
REQ-029 SHALL place opcode localparams, alu_ctrl enum and a packed control struct in shared package decode_pkg.
REQ-030 SHALL use one combinational sub-module decode_lut (opcode, type bits -> control struct, illegal, is_vector).

Verification
REQ-031 SHALL check: opcode 11000 scalar, out_ready=1 -> next cycle out_valid=1, alu_ctrl=00, reg_write=1, last_beat=1, illegal=0.
REQ-032 SHALL check: LANES=4, ALU_LANES=1, opcode 11111 all vector -> 4 beats lane_base 0,1,2,3, alu_ctrl=10, last_beat only on 3, in_ready=0 during beats 0-2.
REQ-033 SHALL check: out_ready=0 for 3 cycles mid-vector at lane_base=1 -> outputs frozen, then resume at 2.
REQ-034 SHALL check: opcode 00100 with rs1_type=1, and opcode 00000 -> illegal=1, all controls 0, single beat.
REQ-035 SHALL check: back-to-back scalar 01100 then 11110 with out_ready=1 -> consecutive beats, no bubble; rst asserted at lane_base=2 of vector -> next cycle out_valid=0, lane_base=0.
